mpc_muldiv_sequencer: RTL and testbench
=======================================

MPC_MULDIV_SEQUENCER -- requirements
Module: mpc_muldiv_sequencer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, operand/result width; OP_WIDTH, default 3, operation code width; MAX_WAIT, default 64, watchdog limit in cycles.
REQ-002 SHALL use one clock and a synchronous, active-high reset; reset port resetn is asserted = 1 despite its name.
REQ-003 SHALL have these ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-high reset
- iValid  in  1  request present
- iOp  in  OP_WIDTH  operation code
- iA  in  DATA_WIDTH  operand A / move-to value
- iB  in  DATA_WIDTH  operand B
- iFlush  in  1  abort in-flight mul/div
- oReady  out  1  request accepted when iValid & oReady
- oResult  out  DATA_WIDTH  MFHI/MFLO read data
- oResultValid  out  1  oResult valid, one-cycle pulse
- oUnitValid  out  1  start pulse to shared mul/div unit
- oUnitDiv  out  1  1 = divide, 0 = multiply
- oUnitSign  out  1  signed operation
- oUnitA, oUnitB  out  DATA_WIDTH  latched operands
- iUnitReady  in  1  unit result valid
- iUnitHi, iUnitLo  in  DATA_WIDTH  unit result
- oDivZero  out  1  divide-by-zero pulse
- oTimeout  out  1  watchdog expiry pulse

Function
REQ-004 SHALL decode iOp as MULT=0, MULTU=1, DIV=2, DIVU=3, MFHI=4, MFLO=5, MTHI=6, MTLO=7.
REQ-005 SHALL implement an FSM with states IDLE, ISSUE, WAIT and DRAIN.
REQ-006 SHALL drive oReady=1 only in IDLE.
REQ-007 SHALL hold internal HI and LO registers, which are only updated as specified below.
REQ-008 In IDLE, on an accepted MFHI or MFLO, SHALL drive HI or LO on oResult with oResultValid=1 on the next cycle; the FSM stays in IDLE.
REQ-009 In IDLE, on an accepted MTHI or MTLO, SHALL write iA to HI or LO, visible on the next cycle.
REQ-010 On an accepted MULT or MULTU, SHALL latch iA and iB into oUnitA and oUnitB and go to ISSUE.
REQ-011 On an accepted DIV or DIVU, SHALL latch iA and iB into oUnitA and oUnitB and go to ISSUE.
REQ-012 On an accepted DIV or DIVU with iB==0, SHALL not issue, SHALL pulse oDivZero on the next cycle, SHALL leave HI and LO unchanged, and SHALL stay in IDLE.
REQ-013 SHALL drive oUnitSign=1 for MULT and DIV, and oUnitDiv=1 for DIV and DIVU; both are held stable from ISSUE until return to IDLE.
REQ-014 ISSUE SHALL assert oUnitValid for exactly one cycle, then go to WAIT; accept-to-oUnitValid latency is 1 cycle.
REQ-015 In WAIT, on iUnitReady, SHALL load HI=iUnitHi and LO=iUnitLo at the clock edge and return to IDLE; a new request is accepted the next cycle.
REQ-016 On a divide, HI SHALL hold the remainder and LO the quotient, as supplied by the unit.
REQ-017 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-018 If the wait counter reaches MAX_WAIT without iUnitReady, SHALL pulse oTimeout, leave HI/LO unchanged and go to IDLE; the counter is log2(MAX_WAIT)+1 bits and SHALL not wrap.
REQ-019 iFlush in ISSUE SHALL suppress oUnitValid and return to IDLE.
REQ-020 iFlush in WAIT without iUnitReady SHALL go to DRAIN.
REQ-021 iFlush and iUnitReady in the same WAIT cycle SHALL discard the result and go to IDLE.
REQ-022 DRAIN SHALL discard the result on iUnitReady and go to IDLE; the MAX_WAIT watchdog SHALL also apply in DRAIN.
REQ-023 iFlush in IDLE SHALL have no effect; a request presented with iFlush in IDLE is still accepted.
REQ-024 iUnitReady outside WAIT and DRAIN SHALL be ignored.
REQ-025 oResultValid, oDivZero, oTimeout and oUnitValid SHALL be single-cycle pulses.

Reset
REQ-026 When resetn=1 at a clock edge, SHALL enter IDLE and clear HI, LO, the wait counter, oResult, all pulse outputs, oUnitA, oUnitB, oUnitDiv and oUnitSign to 0; an in-flight operation is abandoned and a late iUnitReady is ignored.

Structure
REQ-027 Op codes, state encodings and DATA_WIDTH/OP_WIDTH defaults SHALL reside in the shared mpc package/defines.
REQ-028 The design SHALL be one module; the watchdog counter MAY be a sub-module mpc_wait_counter.

Verification
REQ-029 MULT with iA=0xFFFFFFFE (-2), iB=3 -> oUnitSign=1, oUnitValid 1 cycle after accept; unit returns Hi=0xFFFFFFFF, Lo=0xFFFFFFFA after 5 cycles; following MFLO -> oResult=0xFFFFFFFA.
REQ-030 DIVU with iA=7, iB=0 -> oDivZero pulse, no oUnitValid; MFHI -> prior HI value.
REQ-031 MTHI iA=0x12345678, then MFHI -> oResult=0x12345678 with oResultValid two cycles after the MTHI accept.
REQ-032 DIV issued, iFlush in the 2nd WAIT cycle, iUnitReady 3 cycles later with Hi=1, Lo=2 -> DRAIN discards; HI/LO unchanged; oReady=1 the following cycle.
REQ-033 MULTU issued, unit never responds, MAX_WAIT=8 -> oTimeout after 8 WAIT cycles, then IDLE.
REQ-034 resetn=1 during WAIT, then iUnitReady -> HI=LO=0 and all outputs 0.

Source files
------------

// File: rtl/mpc_muldiv_sequencer_pkg.sv
// Shared definitions for the MIPS-style HI/LO multiply/divide sequencer:
// default widths, operation codes and sequencer state encoding.
package mpc_pkg;

  localparam int unsigned MPC_DATA_WIDTH = 32;
  localparam int unsigned MPC_OP_WIDTH   = 3;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/mpc_muldiv_sequencer_wait_counter.sv
// Watchdog for the mul/div unit: counts cycles while run is high, clears
// otherwise, saturates at MAX_WAIT and flags the last permitted cycle.
module mpc_wait_counter #(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  // High during the MAX_WAIT-th counted cycle; the count reaches MAX_WAIT at its end.
  assign expire = run && (count == LIMIT - CW'(1));

endmodule

// File: rtl/mpc_muldiv_sequencer.sv
// Sequences MULT/DIV requests to a shared mul/div unit and owns the HI/LO
// registers, with flush, divide-by-zero and watchdog handling.
module mpc_muldiv_sequencer
  import mpc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MPC_DATA_WIDTH,
  parameter int unsigned OP_WIDTH   = MPC_OP_WIDTH,
  parameter int unsigned MAX_WAIT   = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  iValid,
  input  logic [OP_WIDTH-1:0]   iOp,
  input  logic [DATA_WIDTH-1:0] iA,
  input  logic [DATA_WIDTH-1:0] iB,
  input  logic                  iFlush,
  output logic                  oReady,
  output logic [DATA_WIDTH-1:0] oResult,
  output logic                  oResultValid,
  output logic                  oUnitValid,
  output logic                  oUnitDiv,
  output logic                  oUnitSign,
  output logic [DATA_WIDTH-1:0] oUnitA,
  output logic [DATA_WIDTH-1:0] oUnitB,
  input  logic                  iUnitReady,
  input  logic [DATA_WIDTH-1:0] iUnitHi,
  input  logic [DATA_WIDTH-1:0] iUnitLo,
  output logic                  oDivZero,
  output logic                  oTimeout
);

  state_e state, state_next;
  op_e    op;

  logic [DATA_WIDTH-1:0] hi, lo;
  logic accept, issue, div_zero, unit_valid, load_hilo, timeout, counting, expire;
  logic mul_op, div_op;

  assign op     = op_e'(iOp[2:0]);
  assign mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign div_op = (op == OP_DIV)  || (op == OP_DIVU);

  assign counting = (state == ST_WAIT) || (state == ST_DRAIN);

  mpc_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_counter (
    .clk    (clk),
    .rst    (resetn),
    .run    (counting),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (resetn) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    div_zero   = 1'b0;
    unit_valid = 1'b0;
    load_hilo  = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iValid) begin
          accept = 1'b1;
          if (mul_op || (div_op && iB != '0)) begin
            issue      = 1'b1;
            state_next = ST_ISSUE;
          end else if (div_op) begin
            div_zero = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        unit_valid = !iFlush;
        state_next = iFlush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        // A response wins over the watchdog; the watchdog wins over a flush.
        if (iUnitReady) begin
          load_hilo  = !iFlush;
          state_next = ST_IDLE;
        end else if (expire) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end else if (iFlush) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (iUnitReady) begin
          state_next = ST_IDLE;
        end else if (expire) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign oReady     = (state == ST_IDLE);
  assign oUnitValid = unit_valid;

  always_ff @(posedge clk) begin
    if (resetn) begin
      hi           <= '0;
      lo           <= '0;
      oResult      <= '0;
      oResultValid <= 1'b0;
      oDivZero     <= 1'b0;
      oTimeout     <= 1'b0;
      oUnitA       <= '0;
      oUnitB       <= '0;
      oUnitDiv     <= 1'b0;
      oUnitSign    <= 1'b0;
    end else begin
      oResultValid <= 1'b0;
      oDivZero     <= div_zero;
      oTimeout     <= timeout;
      if (accept) begin
        case (op)
          OP_MFHI: begin oResult <= hi; oResultValid <= 1'b1; end
          OP_MFLO: begin oResult <= lo; oResultValid <= 1'b1; end
          OP_MTHI: hi <= iA;
          OP_MTLO: lo <= iA;
          default: ;
        endcase
      end
      if (issue) begin
        oUnitA    <= iA;
        oUnitB    <= iB;
        oUnitDiv  <= div_op;
        oUnitSign <= (op == OP_MULT) || (op == OP_DIV);
      end
      if (load_hilo) begin
        hi <= iUnitHi;
        lo <= iUnitLo;
      end
    end
  end

endmodule

// File: tb/tb_mpc_muldiv_sequencer.sv
// Randomized bench for mpc_muldiv_sequencer: a bench-side unit model answers
// requests and a HI/LO reference model is checked through MFHI/MFLO reads.
module tb_mpc_muldiv_sequencer;

  localparam int DW = 32;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          iValid = 1'b0;
  logic [2:0]    iOp = '0;
  logic [DW-1:0] iA = '0, iB = '0;
  logic          iFlush = 1'b0;
  logic          oReady, oResultValid, oUnitValid, oUnitDiv, oUnitSign, oDivZero, oTimeout;
  logic [DW-1:0] oResult, oUnitA, oUnitB;
  logic          iUnitReady = 1'b0;
  logic [DW-1:0] iUnitHi = '0, iUnitLo = '0;

  mpc_muldiv_sequencer #(.DATA_WIDTH(DW), .OP_WIDTH(3), .MAX_WAIT(MW)) dut (
    .clk(clk), .resetn(resetn), .iValid(iValid), .iOp(iOp), .iA(iA), .iB(iB),
    .iFlush(iFlush), .oReady(oReady), .oResult(oResult), .oResultValid(oResultValid),
    .oUnitValid(oUnitValid), .oUnitDiv(oUnitDiv), .oUnitSign(oUnitSign),
    .oUnitA(oUnitA), .oUnitB(oUnitB), .iUnitReady(iUnitReady), .iUnitHi(iUnitHi),
    .iUnitLo(iUnitLo), .oDivZero(oDivZero), .oTimeout(oTimeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] m_hi = '0, m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void model_unit(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     output logic [DW-1:0] h, output logic [DW-1:0] l);
    longint p;
    logic [63:0] pb;
    h = '0;
    l = '0;
    case (op)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); pb = p; h = pb[63:32]; l = pb[31:0]; end
      3'd1: begin pb = {32'b0, a} * {32'b0, b}; h = pb[63:32]; l = pb[31:0]; end
      3'd2: begin h = $signed(a) % $signed(b); l = $signed(a) / $signed(b); end
      default: begin h = a % b; l = a / b; end
    endcase
  endfunction

  task automatic read_reg(input logic sel_hi);
    check("ready_mf", oReady, 1);
    iValid = 1; iOp = sel_hi ? 3'd4 : 3'd5; iA = $urandom; iFlush = 1'($urandom_range(0, 1));
    tick();
    iValid = 0; iFlush = 0;
    check("mf_valid", oResultValid, 1);
    check(sel_hi ? "mfhi" : "mflo", oResult, sel_hi ? m_hi : m_lo);
    tick();
    check("mf_pulse", oResultValid, 0);
  endtask

  task automatic write_reg(input logic sel_hi, input logic [DW-1:0] val);
    check("ready_mt", oReady, 1);
    iValid = 1; iOp = sel_hi ? 3'd6 : 3'd7; iA = val; iFlush = 1'($urandom_range(0, 1));
    tick();
    iValid = 0; iFlush = 0;
    if (sel_hi) m_hi = val; else m_lo = val;
    check("mt_no_result", oResultValid, 0);
  endtask

  // resp_at / flush_at: WAIT-phase cycle numbers (1-based) of the unit
  // response and of the flush; 0 means the event never happens.
  task automatic muldiv(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int resp_at, input int flush_at, input logic flush_issue);
    logic [DW-1:0] eh, el;
    bit done, timed;
    done = 0; timed = 0; eh = '0; el = '0;
    if (!(op[1] && b == 0)) model_unit(op, a, b, eh, el);
    check("ready_req", oReady, 1);
    iValid = 1; iOp = op; iA = a; iB = b;
    tick();
    iValid = 0;
    if (op[1] && b == 0) begin
      check("divzero", oDivZero, 1);
      check("divzero_novalid", oUnitValid, 0);
      check("divzero_ready", oReady, 1);
      tick();
      check("divzero_pulse", oDivZero, 0);
      return;
    end
    check("unit_a", oUnitA, a);
    check("unit_b", oUnitB, b);
    check("unit_div", oUnitDiv, op[1]);
    check("unit_sign", oUnitSign, !op[0]);
    check("busy_issue", oReady, 0);
    iFlush = flush_issue;
    #1;
    check("unit_valid", oUnitValid, !flush_issue);
    tick();
    iFlush = 0;
    check("unit_valid_pulse", oUnitValid, 0);
    if (flush_issue) begin
      check("ready_after_issue_flush", oReady, 1);
      return;
    end
    for (int w = 1; w <= MW && !done; w++) begin
      check("busy_wait", oReady, 0);
      check("no_timeout", oTimeout, 0);
      check("div_stable", oUnitDiv, op[1]);
      iUnitReady = (w == resp_at); iUnitHi = eh; iUnitLo = el; iFlush = (w == flush_at);
      if (w == resp_at) begin
        done = 1;
        if (flush_at == 0 || flush_at > w) begin m_hi = eh; m_lo = el; end
      end else if (w == MW) begin
        done = 1; timed = 1;
      end
      tick();
      iUnitReady = 0; iFlush = 0;
    end
    check("ready_done", oReady, 1);
    check("timeout", oTimeout, timed);
    check("no_unit_valid", oUnitValid, 0);
    if (timed) begin
      tick();
      check("timeout_pulse", oTimeout, 0);
    end
  endtask

  initial begin
    logic [2:0] op;
    logic [DW-1:0] a, b;
    int k;

    tick(); tick();
    resetn = 0;
    check("rst_ready", oReady, 1);
    check("rst_result", oResult, 0);
    check("rst_rvalid", oResultValid, 0);
    check("rst_uvalid", oUnitValid, 0);
    check("rst_ua", oUnitA, 0);
    check("rst_ub", oUnitB, 0);
    check("rst_udiv", oUnitDiv, 0);
    check("rst_usign", oUnitSign, 0);
    check("rst_divzero", oDivZero, 0);
    check("rst_timeout", oTimeout, 0);
    read_reg(1); read_reg(0);

    // MULT -2 * 3, response after 5 cycles
    muldiv(3'd0, 32'hFFFF_FFFE, 32'd3, 5, 0, 0);
    check("req029_hi", m_hi, 32'hFFFF_FFFF);
    check("req029_lo", m_lo, 32'hFFFF_FFFA);
    read_reg(0); read_reg(1);
    // MTHI / MFHI back to back
    write_reg(1, 32'h1234_5678);
    read_reg(1);
    // DIVU by zero leaves HI alone
    muldiv(3'd3, 32'd7, 32'd0, 0, 0, 0);
    read_reg(1);
    // DIV flushed in 2nd WAIT cycle, response drained 3 cycles later
    muldiv(3'd2, 32'd100, 32'd7, 5, 2, 0);
    read_reg(1); read_reg(0);
    // MULTU with no response hits the watchdog
    muldiv(3'd1, 32'd9, 32'd9, 0, 0, 0);
    read_reg(1); read_reg(0);
    // flush and response together
    muldiv(3'd1, 32'd4, 32'd5, 3, 3, 0);
    read_reg(0);

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      if (k < 5) begin
        op = 3'($urandom_range(0, 3));
        a = $urandom;
        b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        if ($urandom_range(0, 1) == 0) b = b & 32'h0000_00FF;
        if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
        muldiv(op, a, b, $urandom_range(0, MW),
               ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, MW),
               ($urandom_range(0, 9) == 0));
      end else if (k < 7) begin
        write_reg(1'($urandom_range(0, 1)), $urandom);
      end else if (k < 9) begin
        read_reg(1'($urandom_range(0, 1)));
      end else begin
        // stray unit response while idle must not touch HI/LO
        iUnitReady = 1; iUnitHi = $urandom; iUnitLo = $urandom;
        tick();
        iUnitReady = 0;
        check("stray_ready", oReady, 1);
        check("stray_rvalid", oResultValid, 0);
      end
    end
    read_reg(1); read_reg(0);

    // reset during WAIT, then a late unit response
    iValid = 1; iOp = 3'd0; iA = 32'd5; iB = 32'd6;
    tick();
    iValid = 0;
    tick(); tick();
    check("rstw_busy", oReady, 0);
    resetn = 1;
    tick();
    resetn = 0;
    m_hi = '0; m_lo = '0;
    check("rstw_ready", oReady, 1);
    check("rstw_ua", oUnitA, 0);
    check("rstw_ub", oUnitB, 0);
    check("rstw_sign", oUnitSign, 0);
    check("rstw_result", oResult, 0);
    iUnitReady = 1; iUnitHi = 32'hDEAD_BEEF; iUnitLo = 32'hCAFE_F00D;
    tick();
    iUnitReady = 0;
    check("rstw_rvalid", oResultValid, 0);
    check("rstw_uvalid", oUnitValid, 0);
    check("rstw_timeout", oTimeout, 0);
    check("rstw_divzero", oDivZero, 0);
    read_reg(1); read_reg(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
